// File: rtl/switch_debounce_scheduler_pkg.sv
// Shared constants, event-FSM state type and id-width helper
// for the switch debounce scheduler.
package switch_debounce_scheduler_pkg;

    localparam int DEF_TICK_DIVIDE  = 25000;
    localparam int DEF_STABLE_TICKS = 10;

    typedef enum logic {
        EV_IDLE    = 1'b0,
        EV_PRESENT = 1'b1
    } ev_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_debounce_scheduler_debounce_channel.sv
// One debounce channel: stability counter plus accepted level.
// Ports: clk, rst_n, tick (sample enable), raw (input level),
//        level (debounced), flip (high in the cycle a change is accepted).
module switch_debounce_scheduler_debounce_channel #(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic flip
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          flip_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        flip_d  = 1'b0;
        if (tick) begin
            if (raw == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                level_d = raw;
                cnt_d   = '0;
                flip_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign flip  = flip_d;

endmodule

// File: rtl/switch_debounce_scheduler.sv
// Debounces NUM_SWITCHES inputs and serialises press/release events
// onto one valid/ready port with a round-robin arbiter.
// Ports: i_Clk, i_Rst_L (async low), i_Switch (raw), o_Switch (debounced),
//        o_Event_Valid/Id/Level + i_Event_Ready (event port),
//        o_Overflow (sticky) + i_Overflow_Clr.
// Define SWITCH_SYNC_EN to insert a 2-flop synchroniser on i_Switch.
module switch_debounce_scheduler
    import switch_debounce_scheduler_pkg::*;
#(
    parameter int NUM_SWITCHES = 4,
    parameter int TICK_DIVIDE  = DEF_TICK_DIVIDE,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst_L,
    input  logic [NUM_SWITCHES-1:0]           i_Switch,
    output logic [NUM_SWITCHES-1:0]           o_Switch,
    output logic                              o_Event_Valid,
    output logic [id_width(NUM_SWITCHES)-1:0] o_Event_Id,
    output logic                              o_Event_Level,
    input  logic                              i_Event_Ready,
    output logic                              o_Overflow,
    input  logic                              i_Overflow_Clr
);

    localparam int IW = id_width(NUM_SWITCHES);
    localparam int PW = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;

    logic [PW-1:0]           presc_q;
    logic [PW-1:0]           presc_d;
    logic                    tick;
    logic [NUM_SWITCHES-1:0] sw_in;
    logic [NUM_SWITCHES-1:0] flip;

    logic [NUM_SWITCHES-1:0] pending_q;
    logic [NUM_SWITCHES-1:0] pending_d;
    logic [NUM_SWITCHES-1:0] pend_level_q;
    logic [NUM_SWITCHES-1:0] pend_level_d;
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    ovf_set;

    ev_state_e               state_q;
    ev_state_e               state_d;
    logic                    valid_q;
    logic                    valid_d;
    logic [IW-1:0]           id_q;
    logic [IW-1:0]           id_d;
    logic                    level_q;
    logic                    level_d;
    logic [IW-1:0]           ptr_q;
    logic [IW-1:0]           ptr_d;

    logic                    gnt_found;
    logic [IW-1:0]           gnt_idx;
    logic [NUM_SWITCHES-1:0] grant;

    always_comb begin
        tick    = (presc_q == PW'(TICK_DIVIDE - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

`ifdef SWITCH_SYNC_EN
    logic [NUM_SWITCHES-1:0] sync1_q;
    logic [NUM_SWITCHES-1:0] sync2_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
        end
    end

    assign sw_in = sync2_q;
`else
    assign sw_in = i_Switch;
`endif

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
        switch_debounce_scheduler_debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk   (i_Clk),
            .rst_n (i_Rst_L),
            .tick  (tick),
            .raw   (sw_in[g]),
            .level (o_Switch[g]),
            .flip  (flip[g])
        );
    end

    // First pending channel at or after the pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_SWITCHES; k++) begin
            if (!gnt_found &&
                pending_q[(int'(ptr_q) + k) % NUM_SWITCHES]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(ptr_q) + k) % NUM_SWITCHES);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        level_d = level_q;
        ptr_d   = ptr_q;
        grant   = '0;
        unique case (state_q)
            EV_IDLE: begin
                if (gnt_found) begin
                    grant[gnt_idx] = 1'b1;
                    id_d           = gnt_idx;
                    level_d        = pend_level_q[gnt_idx];
                    valid_d        = 1'b1;
                    state_d        = EV_PRESENT;
                    if (int'(gnt_idx) == NUM_SWITCHES - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_idx + 1'b1;
                    end
                end
            end
            EV_PRESENT: begin
                if (i_Event_Ready) begin
                    valid_d = 1'b0;
                    state_d = EV_IDLE;
                end
            end
            default: begin
                state_d = EV_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // A new flip wins over a same-cycle grant; it only counts as an
    // overwrite when the old event was not just handed to the port.
    always_comb begin
        pending_d    = pending_q;
        pend_level_d = pend_level_q;
        ovf_set      = 1'b0;
        for (int i = 0; i < NUM_SWITCHES; i++) begin
            if (flip[i]) begin
                pending_d[i]    = 1'b1;
                pend_level_d[i] = sw_in[i];
                if (pending_q[i] && !grant[i]) begin
                    ovf_set = 1'b1;
                end
            end else if (grant[i]) begin
                pending_d[i] = 1'b0;
            end
        end
        ovf_d = i_Overflow_Clr ? 1'b0 : (ovf_q | ovf_set);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            presc_q      <= '0;
            pending_q    <= '0;
            pend_level_q <= '0;
            ovf_q        <= 1'b0;
            state_q      <= EV_IDLE;
            valid_q      <= 1'b0;
            id_q         <= '0;
            level_q      <= 1'b0;
            ptr_q        <= '0;
        end else begin
            presc_q      <= presc_d;
            pending_q    <= pending_d;
            pend_level_q <= pend_level_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            valid_q      <= valid_d;
            id_q         <= id_d;
            level_q      <= level_d;
            ptr_q        <= ptr_d;
        end
    end

    assign o_Event_Valid = valid_q;
    assign o_Event_Id    = id_q;
    assign o_Event_Level = level_q;
    assign o_Overflow    = ovf_q;

endmodule

// File: tb/tb_switch_debounce_scheduler.sv
// Bench for switch_debounce_scheduler: directed steps plus a random
// phase, checked against a tick-level debounce model and event queue.
module tb_switch_debounce_scheduler;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         i_Clk          = 1'b0;
    logic         i_Rst_L        = 1'b0;
    logic [N-1:0] i_Switch       = '0;
    logic         i_Event_Ready  = 1'b0;
    logic         i_Overflow_Clr = 1'b0;
    logic [N-1:0] o_Switch;
    logic         o_Event_Valid;
    logic [1:0]   o_Event_Id;
    logic         o_Event_Level;
    logic         o_Overflow;

    switch_debounce_scheduler #(
        .NUM_SWITCHES(N),
        .TICK_DIVIDE (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_Switch      (i_Switch),
        .o_Switch      (o_Switch),
        .o_Event_Valid (o_Event_Valid),
        .o_Event_Id    (o_Event_Id),
        .o_Event_Level (o_Event_Level),
        .i_Event_Ready (i_Event_Ready),
        .o_Overflow    (o_Overflow),
        .i_Overflow_Clr(i_Overflow_Clr)
    );

    always #5 i_Clk = ~i_Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: tick phase, per-channel run length of
    // disagreeing ticks, accepted level, and expected events (id*2+lvl).
    int           presc;
    int           cnt [N];
    logic [N-1:0] deb;
    logic [N-1:0] s1;
    logic [N-1:0] s2;
    int           exp_q [$];
    int           got_id [$];
    int           got_lvl [$];
    bit           model_ev = 1'b1;
    int           cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        presc = 0;
        deb   = '0;
        s1    = '0;
        s2    = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        exp_q.delete();
    endtask

    task automatic cycle();
        logic [N-1:0] eff;
        bit           tk;
        bit           hs;
        bit           hold;
        int           hid;
        logic         hl;
        int           k;
`ifdef SWITCH_SYNC_EN
        eff = s2;
        s2  = s1;
        s1  = i_Switch;
`else
        eff = i_Switch;
`endif
        tk    = (presc == TD - 1);
        presc = tk ? 0 : presc + 1;
        if (tk) begin
            for (int i = 0; i < N; i++) begin
                if (eff[i] == deb[i]) begin
                    cnt[i] = 0;
                end else if (cnt[i] + 1 >= ST) begin
                    deb[i] = eff[i];
                    cnt[i] = 0;
                    exp_q.push_back(i * 2 + int'(eff[i]));
                end else begin
                    cnt[i]++;
                end
            end
        end
        hs   = o_Event_Valid && i_Event_Ready;
        hold = o_Event_Valid && !i_Event_Ready;
        hid  = int'(o_Event_Id);
        hl   = o_Event_Level;
        @(posedge i_Clk);
        #1;
        cyc++;
        chk("o_switch", o_Switch, deb);
        if (hold) begin
            chk("hold_valid", o_Event_Valid, 1);
            chk("hold_id", o_Event_Id, hid);
            chk("hold_level", o_Event_Level, hl);
        end
        if (hs) begin
            got_id.push_back(hid);
            got_lvl.push_back(int'(hl));
            if (model_ev) begin
                k = -1;
                foreach (exp_q[j]) if (k < 0 && exp_q[j] / 2 == hid) k = j;
                chk("ev_known_id", (k >= 0), 1);
                if (k >= 0) begin
                    chk("ev_level", hl, exp_q[k] % 2);
                    exp_q.delete(k);
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int sw_rise;
        int v_rise;
        int b;
        int exp_order [3];
        exp_order[0] = 0;
        exp_order[1] = 1;
        exp_order[2] = 3;

        // Power-on reset.
        repeat (3) @(posedge i_Clk);
        #1;
        i_Rst_L = 1'b1;
        model_reset();

        // Build up state, then reset mid-operation.
        i_Switch[3] = 1'b1;
        run(8);
        i_Switch[1] = 1'b1;
        run(8);
        chk("pre_reset_valid", o_Event_Valid, 1);
        chk("pre_reset_id", o_Event_Id, 3);
        chk("pre_reset_sw", o_Switch, 4'b1000);
        #3;
        i_Rst_L = 1'b0;
        #1;
        chk("rst_switch", o_Switch, 0);
        chk("rst_valid", o_Event_Valid, 0);
        chk("rst_id", o_Event_Id, 0);
        chk("rst_level", o_Event_Level, 0);
        chk("rst_ovf", o_Overflow, 0);
        @(posedge i_Clk);
        #1;
        chk("rst_held_switch", o_Switch, 0);
        i_Rst_L = 1'b1;
        model_reset();
        i_Event_Ready = 1'b1;
        run(20);
        chk("rst_drain", exp_q.size(), 0);

        // Clean press on channel 2 with the consumer stalled.
        i_Event_Ready = 1'b0;
        i_Switch[2]   = 1'b1;
        sw_rise = -1;
        v_rise  = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (o_Switch[2] && sw_rise < 0) sw_rise = cyc;
            if (o_Event_Valid && v_rise < 0) v_rise = cyc;
        end
        chk("press_seen", (sw_rise >= 0), 1);
        chk("press_latency", v_rise - sw_rise, 1);
        chk("press_id", o_Event_Id, 2);
        chk("press_level", o_Event_Level, 1);
        run(10);
        chk("press_still_valid", o_Event_Valid, 1);
        i_Event_Ready = 1'b1;
        cycle();
        chk("press_gap", o_Event_Valid, 0);
        run(4);
        chk("press_drain", exp_q.size(), 0);

        // Two-tick glitch on channel 0.
        b = got_id.size();
        i_Switch[0] = 1'b1;
        run(8);
        i_Switch[0] = 1'b0;
        run(20);
        chk("glitch_level", o_Switch[0], 0);
        chk("glitch_no_event", got_id.size() - b, 0);

        // Move the pointer past channel 3 so it wraps to 0.
        i_Switch[3] = ~i_Switch[3];
        run(20);
        chk("wrap_last_id", got_id[got_id.size()-1], 3);

        // Two simultaneous batches on channels 0, 1, 3.
        for (int batch = 0; batch < 2; batch++) begin
            got_id.delete();
            got_lvl.delete();
            i_Switch = i_Switch ^ 4'b1011;
            run(24);
            chk("batch_count", got_id.size(), 3);
            for (int i = 0; i < 3 && i < got_id.size(); i++) begin
                chk("batch_order", got_id[i], exp_order[i]);
            end
        end
        chk("batch_drain", exp_q.size(), 0);
        chk("batch_ovf", o_Overflow, 0);

        // Overwrite a pending event on channel 0.
        model_ev = 1'b0;
        got_id.delete();
        got_lvl.delete();
        i_Event_Ready = 1'b0;
        i_Switch[0] = 1'b1;
        run(20);
        i_Switch[0] = 1'b0;
        run(20);
        chk("ovf_before", o_Overflow, 0);
        i_Switch[0] = 1'b1;
        run(20);
        chk("ovf_set", o_Overflow, 1);
        i_Switch[0] = 1'b0;
        run(20);
        i_Event_Ready = 1'b1;
        run(10);
        chk("ovf_ev_count", got_id.size(), 2);
        if (got_id.size() == 2) begin
            chk("ovf_ev0_id", got_id[0], 0);
            chk("ovf_ev0_lvl", got_lvl[0], 1);
            chk("ovf_ev1_id", got_id[1], 0);
            chk("ovf_ev1_lvl", got_lvl[1], 0);
        end
        chk("ovf_sticky", o_Overflow, 1);
        i_Overflow_Clr = 1'b1;
        cycle();
        i_Overflow_Clr = 1'b0;
        chk("ovf_clr", o_Overflow, 0);
        exp_q.delete();
        model_ev = 1'b1;

        // Random toggling with the consumer always ready.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = int'($urandom_range(0, N - 1));
                i_Switch[b] = ~i_Switch[b];
            end
            cycle();
            chk("rand_ovf", o_Overflow, 0);
        end
        run(40);
        chk("rand_drain", exp_q.size(), 0);
        chk("rand_idle", o_Event_Valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
